multi_switch_toggle: RTL and testbench
======================================

// Module: multi_switch_toggle
// PURPOSE
// N-channel successor of the single-switch toggle: synchronises and debounces
// NUM_CH raw switch inputs, detects press/release edges per channel, and keeps
// one toggle LED per channel. Adds a selectable toggle edge and long-press
// detection, which forces the channel LED off. Sits between board switch pins
// and LED pins; the edge and long-press pulses also feed other user logic.
// PARAMETERS
// NUM_CH           4         number of independent switch/LED channels (>=1)
// DEBOUNCE_LIMIT   250000    consecutive clocks a new level must persist (>=2)
// EDGE_MODE        0         toggle on: 0 release, 1 press, 2 both edges
// LONG_PRESS_LIMIT 25000000  clocks held pressed before long-press; 0 disables
// PORTS
// i_Clk          in   1       system clock; all logic on rising edge
// i_Rst_L        in   1       asynchronous reset, active low
// i_Switch       in   NUM_CH  raw switch levels, 1 = pressed, asynchronous
// o_Switch       out  NUM_CH  debounced switch levels
// o_Edge         out  NUM_CH  1-cycle pulse on each debounced edge that toggles
// o_Long_Press   out  NUM_CH  1-cycle pulse when long-press threshold reached
// o_LED          out  NUM_CH  toggle state per channel
// BEHAVIOUR
// - Reset (i_Rst_L=0, async): synchroniser flops, counters, o_Switch, o_Edge,
//   o_Long_Press, o_LED and suppress flags all 0. Reset takes effect
//   immediately, mid-operation included. No pulses are emitted on deassertion.
// - Per channel, fully independent (any mix of channels may act in one cycle):
//   2-flop synchroniser -> debounce -> registered edge/long-press logic.
// - Debounce: counter width $clog2(DEBOUNCE_LIMIT). If synced != o_Switch,
//   counter increments. When counter == DEBOUNCE_LIMIT-1 on such an edge,
//   o_Switch <= synced and counter <= 0. If synced == o_Switch, counter <= 0.
//   A glitch shorter than DEBOUNCE_LIMIT clocks never changes o_Switch.
// - Latency: a clean level change on i_Switch reaches o_Switch 2+DEBOUNCE_LIMIT
//   edges later. o_Edge/o_LED update on the next edge (total 3+DEBOUNCE_LIMIT).
// - Edge select: press = o_Switch 0->1, release = 1->0. A qualifying edge per
//   EDGE_MODE pulses o_Edge for 1 cycle and inverts o_LED, unless suppressed.
// - Long press: hold counter runs while o_Switch==1 and saturates at
//   LONG_PRESS_LIMIT-1. It clears to 0 while o_Switch==0. On the edge where it
//   reaches LONG_PRESS_LIMIT-1: o_Long_Press pulses 1 cycle, o_LED <= 0, and the
//   suppress flag is set. A suppressed release gives neither o_Edge nor a
//   toggle. Suppress clears when o_Switch returns to 0. Exactly one pulse per
//   hold. With LONG_PRESS_LIMIT=0 the long-press logic is absent; o_Long_Press=0.
// - Precedence within a channel: long-press force-off beats toggle.
// - Counters never wrap: debounce resets at its limit; hold saturates.
// - EDGE_MODE values other than 0/1/2 are illegal (elaboration error).
// TESTING (DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=20, NUM_CH=4, EDGE_MODE=0)
// 1 Reset, then ch0 held 1 for 10 clks, then 0 -> o_Switch[0] rises 6 edges
//   after the input; on release, o_Edge[0] pulses once and o_LED[0]=1. Repeat -> 0.
// 2 ch1 glitches 1 for 3 clks, repeated 5x -> o_Switch[1], o_Edge, o_LED stay 0.
// 3 ch2 held 30 clks -> o_Long_Press[2] pulses once, 20 clks after o_Switch[2]
//   rises; o_LED[2] stays 0. On release, no o_Edge and o_LED[2] stays 0.
// 4 Set LED[3]=1, then long-press ch3 -> LED[3] forced 0 on the pulse cycle.
// 5 All 4 channels press/release on the same cycle -> all o_Edge pulse on the
//   same cycle and all LEDs toggle. Rerun with EDGE_MODE=1 and 2 -> the toggle
//   count matches the selected edges.
// 6 Assert i_Rst_L=0 mid-debounce and mid-hold -> all outputs 0 at once. After
//   release with switch held, a press is seen after 2+4 clks and no spurious pulse.

Source files
------------

// File: rtl/multi_switch_toggle.sv
// Per-channel switch front end: two-flop synchroniser, debounce, edge-selected
// LED toggle and long-press detection that forces the channel LED off.
module multi_switch_toggle #(
  parameter int NUM_CH           = 4,
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int EDGE_MODE        = 0,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Edge,
  output logic [NUM_CH-1:0] o_Long_Press,
  output logic [NUM_CH-1:0] o_LED
);

  localparam int              DB_W     = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam bit              LP_EN    = (LONG_PRESS_LIMIT > 0);
  localparam int              HOLD_W   = (LONG_PRESS_LIMIT > 2) ? $clog2(LONG_PRESS_LIMIT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = LP_EN ? HOLD_W'(LONG_PRESS_LIMIT - 1) : '0;

  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("multi_switch_toggle: EDGE_MODE must be 0, 1 or 2");
  end

  // Hold counter sticks at its ceiling so a long hold never wraps into a second pulse.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic edge_qualifies(input logic is_press, input logic is_rel);
    case (EDGE_MODE)
      0:       return is_rel;
      1:       return is_press;
      default: return is_press | is_rel;
    endcase
  endfunction

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic            sw_meta_p0;
    logic            sw_sync_p1;
    logic            sw_db_p2;
    logic            sw_prev_p3;
    logic [DB_W-1:0] db_cnt;
    logic            edge_p3;
    logic            lp_p3;
    logic            led_p3;
    logic            is_press;
    logic            is_rel;
    logic            lp_hit;
    logic            supp;
    logic            toggle;

    // stage p0/p1: synchronise the asynchronous pin
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        sw_meta_p0 <= 1'b0;
        sw_sync_p1 <= 1'b0;
      end else begin
        sw_meta_p0 <= i_Switch[ch];
        sw_sync_p1 <= sw_meta_p0;
      end
    end

    // stage p2: debounced level
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        sw_db_p2 <= 1'b0;
        db_cnt   <= '0;
      end else if (sw_sync_p1 != sw_db_p2) begin
        if (db_cnt == DB_MAX) begin
          sw_db_p2 <= sw_sync_p1;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end

    if (LP_EN) begin : g_lp
      logic [HOLD_W-1:0] hold_cnt;
      logic              supp_q;

      // Suppress flag masks the release that ends a long press.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          hold_cnt <= '0;
          supp_q   <= 1'b0;
        end else if (!sw_db_p2) begin
          hold_cnt <= '0;
          supp_q   <= 1'b0;
        end else begin
          hold_cnt <= hold_sat_inc(hold_cnt);
          if (lp_hit) supp_q <= 1'b1;
        end
      end

      assign lp_hit = sw_db_p2 & (hold_cnt == HOLD_MAX) & ~supp_q;
      assign supp   = supp_q;
    end else begin : g_no_lp
      assign lp_hit = 1'b0;
      assign supp   = 1'b0;
    end

    assign is_press = sw_db_p2 & ~sw_prev_p3;
    assign is_rel   = ~sw_db_p2 & sw_prev_p3;
    assign toggle   = edge_qualifies(is_press, is_rel) & ~supp & ~lp_hit;

    // stage p3: registered pulses and LED state
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        sw_prev_p3 <= 1'b0;
        edge_p3    <= 1'b0;
        lp_p3      <= 1'b0;
        led_p3     <= 1'b0;
      end else begin
        sw_prev_p3 <= sw_db_p2;
        edge_p3    <= toggle;
        lp_p3      <= lp_hit;
        if (lp_hit)      led_p3 <= 1'b0;
        else if (toggle) led_p3 <= ~led_p3;
      end
    end

    assign o_Switch[ch]     = sw_db_p2;
    assign o_Edge[ch]       = edge_p3;
    assign o_Long_Press[ch] = lp_p3;
    assign o_LED[ch]        = led_p3;
  end

endmodule

// File: tb/tb_multi_switch_toggle.sv
// Bench for multi_switch_toggle: three instances (release, press, both-edge
// modes) share one stimulus; timing of mode-0 pulses is scoreboarded.
module tb_multi_switch_toggle;
  localparam int NCH = 4;
  localparam int DBL = 4;
  localparam int LPL = 20;

  logic           i_Clk    = 1'b0;
  logic           i_Rst_L  = 1'b1;
  logic [NCH-1:0] i_Switch = '0;
  logic [NCH-1:0] sw0, edge0, lp0, led0;
  logic [NCH-1:0] sw1, edge1, lp1, led1;
  logic [NCH-1:0] sw2, edge2, lp2, led2;

  always #5 i_Clk = ~i_Clk;

  multi_switch_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DBL), .EDGE_MODE(0), .LONG_PRESS_LIMIT(LPL)) dut0 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Switch(sw0), .o_Edge(edge0), .o_Long_Press(lp0), .o_LED(led0));
  multi_switch_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DBL), .EDGE_MODE(1), .LONG_PRESS_LIMIT(LPL)) dut1 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Switch(sw1), .o_Edge(edge1), .o_Long_Press(lp1), .o_LED(led1));
  multi_switch_toggle #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DBL), .EDGE_MODE(2), .LONG_PRESS_LIMIT(LPL)) dut2 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Switch(sw2), .o_Edge(edge2), .o_Long_Press(lp2), .o_LED(led2));

  typedef struct {
    int             cyc;
    logic [NCH-1:0] mask;
  } ev_t;

  typedef struct {
    string          name;
    logic [NCH-1:0] mask;
    int             hold;
    logic [1:0]     xchk;
    logic [NCH-1:0] led0;
    logic [NCH-1:0] led1;
    logic [NCH-1:0] led2;
    int             n1;
    int             n2;
  } vec_t;

  ev_t  edge_q[$];
  ev_t  lp_q[$];
  vec_t vecs[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   cnt1   = 0;
  int   cnt2   = 0;
  bit   mon_en = 1'b0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic chk4(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_edge(input int c, input logic [NCH-1:0] m);
    ev_t e;
    e.cyc = c; e.mask = m;
    edge_q.push_back(e);
  endtask

  task automatic push_lp(input int c, input logic [NCH-1:0] m);
    ev_t e;
    e.cyc = c; e.mask = m;
    lp_q.push_back(e);
  endtask

  task automatic add_vec(input string nm, input logic [NCH-1:0] m, input int hold, input logic [1:0] xchk,
                         input logic [NCH-1:0] l0, input logic [NCH-1:0] l1, input logic [NCH-1:0] l2,
                         input int n1, input int n2);
    vec_t v;
    v.name = nm; v.mask = m; v.hold = hold; v.xchk = xchk;
    v.led0 = l0; v.led1 = l1; v.led2 = l2; v.n1 = n1; v.n2 = n2;
    vecs.push_back(v);
  endtask

  // Scoreboard monitors: mode-0 pulses must match queued expectations exactly.
  always @(negedge i_Clk) begin
    ev_t e;
    if (mon_en) begin
      cnt1 += $countones(edge1);
      cnt2 += $countones(edge2);
      if (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
        e = edge_q.pop_front();
        chk4("edge_missed", '0, e.mask);
      end
      if (edge0 != '0) begin
        if (edge_q.size() == 0) chk4("edge_spurious", edge0, '0);
        else begin
          e = edge_q.pop_front();
          chki("edge_cycle", cyc, e.cyc);
          chk4("edge_mask", edge0, e.mask);
        end
      end
    end
  end

  always @(negedge i_Clk) begin
    ev_t e;
    if (mon_en) begin
      if (lp_q.size() > 0 && lp_q[0].cyc < cyc) begin
        e = lp_q.pop_front();
        chk4("lp_missed", '0, e.mask);
      end
      if (lp0 != '0) begin
        if (lp_q.size() == 0) chk4("lp_spurious", lp0, '0);
        else begin
          e = lp_q.pop_front();
          chki("lp_cycle", cyc, e.cyc);
          chk4("lp_mask", lp0, e.mask);
        end
      end
    end
  end

  task automatic set_sw(input logic [NCH-1:0] v);
    @(posedge i_Clk);
    #1;
    i_Switch = v;
  endtask

  // Press mask for 'hold' clocks, release, and wait until all responses settle.
  task automatic press(input logic [NCH-1:0] m, input int hold, input logic [1:0] xchk);
    int n0;
    int n1;
    set_sw(i_Switch | m);
    n0 = cyc;
    if (hold >= LPL) push_lp(n0 + 2 + DBL + LPL, m);
    if (xchk[0]) begin
      while (cyc < n0 + 1 + DBL) @(negedge i_Clk);
      chk4("sw_lat_before", sw0 & m, '0);
      @(negedge i_Clk);
      chk4("sw_lat_rise", sw0 & m, m);
    end
    if (xchk[1]) begin
      while (cyc < n0 + 1 + DBL + LPL) @(negedge i_Clk);
      chk4("led_pre_force", led0 & m, m);
      @(negedge i_Clk);
      chk4("led_forced", led0 & m, '0);
      chk4("lp_on_force", lp0 & m, m);
    end
    while (cyc < n0 + hold - 1) @(negedge i_Clk);
    set_sw(i_Switch & ~m);
    n1 = cyc;
    chki("hold_len", n1 - n0, hold);
    if (hold >= DBL && hold < LPL) push_edge(n1 + 3 + DBL, m);
    while (cyc < n1 + 4 + DBL) @(negedge i_Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    #1 i_Rst_L = 1'b0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk4("rst_dut0", sw0 | edge0 | lp0 | led0, '0);
    chk4("rst_dut1", sw1 | edge1 | lp1 | led1, '0);
    chk4("rst_dut2", sw2 | edge2 | lp2 | led2, '0);
    i_Rst_L = 1'b1;
    mon_en  = 1'b1;
    repeat (4) @(negedge i_Clk);
    chk4("post_rst_quiet", sw0 | edge0 | lp0 | led0 | edge1 | edge2, '0);

    //       name            mask     hold xchk  led0     led1     led2    n1 n2
    add_vec("t1_press_a",   4'b0001, 10, 2'b01, 4'b0001, 4'b0001, 4'b0000, 1, 2);
    add_vec("t1_press_b",   4'b0001, 10, 2'b01, 4'b0000, 4'b0000, 4'b0000, 1, 2);
    for (int g = 0; g < 5; g++)
      add_vec("t2_glitch",  4'b0010,  3, 2'b00, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add_vec("t3_long",      4'b0100, 30, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1, 1);
    add_vec("t4_set",       4'b1000,  8, 2'b00, 4'b1000, 4'b1000, 4'b0000, 1, 2);
    add_vec("t4_long",      4'b1000, 30, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1, 1);
    add_vec("t5_all_a",     4'b1111,  8, 2'b00, 4'b1111, 4'b1111, 4'b0000, 4, 8);
    add_vec("t5_all_b",     4'b1111, 12, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4, 8);
    add_vec("pair",         4'b0011,  6, 2'b00, 4'b0011, 4'b0011, 4'b0000, 2, 4);
    add_vec("db_min",       4'b0100,  4, 2'b00, 4'b0111, 4'b0111, 4'b0000, 1, 2);
    add_vec("lp_below",     4'b0001, 19, 2'b00, 4'b0110, 4'b0110, 4'b0000, 1, 2);
    add_vec("lp_at",        4'b0010, 20, 2'b00, 4'b0100, 4'b0100, 4'b0000, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cnt1 = 0;
      cnt2 = 0;
      press(vecs[i].mask, vecs[i].hold, vecs[i].xchk);
      chk4({vecs[i].name, "_sw"}, sw0, '0);
      chk4({vecs[i].name, "_led0"}, led0, vecs[i].led0);
      chk4({vecs[i].name, "_led1"}, led1, vecs[i].led1);
      chk4({vecs[i].name, "_led2"}, led2, vecs[i].led2);
      chki({vecs[i].name, "_cnt1"}, cnt1, vecs[i].n1);
      chki({vecs[i].name, "_cnt2"}, cnt2, vecs[i].n2);
    end

    // Reset while ch0/ch2 are mid-hold and ch1 is mid-debounce.
    set_sw(4'b0101);
    n0 = cyc;
    while (cyc < n0 + 10) @(negedge i_Clk);
    chk4("t6_held", sw0, 4'b0101);
    chk4("t6_led_pre", led0, 4'b0100);
    set_sw(4'b0111);
    @(negedge i_Clk);
    #2 i_Rst_L = 1'b0;
    #1;
    chk4("t6_rst_dut0", sw0 | edge0 | lp0 | led0, '0);
    chk4("t6_rst_dut1", sw1 | edge1 | lp1 | led1, '0);
    chk4("t6_rst_dut2", sw2 | edge2 | lp2 | led2, '0);
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk4("t6_in_rst", sw0 | led0 | sw1 | led1, '0);
    i_Rst_L = 1'b1;
    n0 = cyc;
    while (cyc < n0 + 1 + DBL) @(negedge i_Clk);
    chk4("t6_sw_before", sw0, '0);
    @(negedge i_Clk);
    chk4("t6_sw_rise", sw0, 4'b0111);
    set_sw(4'b0000);
    n1 = cyc;
    push_edge(n1 + 3 + DBL, 4'b0111);
    while (cyc < n1 + 4 + DBL) @(negedge i_Clk);
    chk4("t6_led0", led0, 4'b0111);
    chk4("t6_sw_low", sw0, '0);

    repeat (3) @(negedge i_Clk);
    chki("sb_drained", edge_q.size() + lp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
